// File: rtl/issue_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// issue_sequencer_pkg
// Shared definitions for the issue sequencer slice:
//   - seq_state_e : FSM encodings (SEQ_PASS = 0, SEQ_REPLAY = 1)
//   - seq_slot_t  : one issue slot packed as {inst, ctrl, pc, pred, tgt}, so a
//                   held instruction lives in a single register vector
//   - SEQ_NOP_INST: instruction word used for empty slots (addi x0,x0,0)
// ----------------------------------------------------------------------------
package issue_sequencer_pkg;

   localparam int          CTRL_W       = 16;
   localparam logic [31:0] SEQ_NOP_INST = 32'h0000_0013;

   typedef enum logic {
      SEQ_PASS   = 1'b0,
      SEQ_REPLAY = 1'b1
   } seq_state_e;

   typedef struct packed {
      logic [31:0]       inst;
      logic [CTRL_W-1:0] ctrl;
      logic [31:0]       pc;
      logic              pred;
      logic [31:0]       tgt;
   } seq_slot_t;

   localparam int SLOT_W = $bits(seq_slot_t);

endpackage

// File: rtl/issue_sequencer_if.sv
// ----------------------------------------------------------------------------
// issue_sequencer_if
// Decode-side pair, issue-side pair and control signals of the sequencer.
//   master : the environment (decode + issue + pipeline control)
//   slave  : the issue_sequencer itself
// ----------------------------------------------------------------------------
interface issue_sequencer_if
   import issue_sequencer_pkg::*;
#(
   parameter int CNT_W = 32
);
   // decode side
   logic              in_valid_i;
   logic              in_ready_o;
   logic [31:0]       in_inst0_i, in_inst1_i;
   logic [CTRL_W-1:0] in_ctrl0_i, in_ctrl1_i;
   logic [31:0]       in_pc0_i,   in_pc1_i;
   logic              in_pred0_i, in_pred1_i;
   logic [31:0]       in_tgt0_i,  in_tgt1_i;
   // pipeline control
   logic              stall_i;
   logic              flush_i;
   logic              issue1_special_stall_i;
   // issue side
   logic [31:0]       out_inst0_o, out_inst1_o;
   logic [CTRL_W-1:0] out_ctrl0_o, out_ctrl1_o;
   logic [31:0]       out_pc0_o,   out_pc1_o;
   logic              out_pred0_o, out_pred1_o;
   logic [31:0]       out_tgt0_o,  out_tgt1_o;
   logic              kill1_o;
   logic [CNT_W-1:0]  replay_cnt_o;

   modport master (
      output in_valid_i, in_inst0_i, in_inst1_i, in_ctrl0_i, in_ctrl1_i,
             in_pc0_i, in_pc1_i, in_pred0_i, in_pred1_i, in_tgt0_i, in_tgt1_i,
             stall_i, flush_i, issue1_special_stall_i,
      input  in_ready_o, out_inst0_o, out_inst1_o, out_ctrl0_o, out_ctrl1_o,
             out_pc0_o, out_pc1_o, out_pred0_o, out_pred1_o, out_tgt0_o, out_tgt1_o,
             kill1_o, replay_cnt_o
   );

   modport slave (
      input  in_valid_i, in_inst0_i, in_inst1_i, in_ctrl0_i, in_ctrl1_i,
             in_pc0_i, in_pc1_i, in_pred0_i, in_pred1_i, in_tgt0_i, in_tgt1_i,
             stall_i, flush_i, issue1_special_stall_i,
      output in_ready_o, out_inst0_o, out_inst1_o, out_ctrl0_o, out_ctrl1_o,
             out_pc0_o, out_pc1_o, out_pred0_o, out_pred1_o, out_tgt0_o, out_tgt1_o,
             kill1_o, replay_cnt_o
   );

endinterface

// File: rtl/issue_hold_reg.sv
// ----------------------------------------------------------------------------
// issue_hold_reg
// Generic slot register with async reset, synchronous clear and load enable.
// Clear wins over enable. Usable as the storage of any one-entry skid buffer.
//   clock_i, reset_i : clock, asynchronous active-high reset
//   clr_i            : synchronous clear back to RST_VAL
//   en_i             : load d_i
//   d_i / q_o        : data in / registered data out
// ----------------------------------------------------------------------------
module issue_hold_reg #(
   parameter int           W       = 8,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clock_i,
   input  logic         reset_i,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_q;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         data_q <= RST_VAL;
      end else if (clr_i) begin
         data_q <= RST_VAL;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/issue_sequencer.sv
// ----------------------------------------------------------------------------
// issue_sequencer
// Presents decode pairs to issue. When issue reports that slot 1 cannot go
// with slot 0, slot 0 issues, slot 1 is killed and parked in a hold register,
// and the parked instruction is replayed alone in slot 0 on the next
// non-stalled cycle while decode is back-pressured.
//   clock_i, reset_i : clock, asynchronous active-high reset
//   bus (slave)      : decode pair in, issue pair out, stall/flush/special
//                      stall in, kill1_o and replay_cnt_o out
// ----------------------------------------------------------------------------
module issue_sequencer
   import issue_sequencer_pkg::*;
#(
   parameter logic [31:0] NOP_INST = SEQ_NOP_INST,
   parameter int          CNT_W    = 32
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   issue_sequencer_if.slave     bus
);

   localparam seq_slot_t NOP_SLOT = '{inst: NOP_INST, ctrl: '0, pc: '0, pred: 1'b0, tgt: '0};

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hold_en, hold_clr;
   seq_slot_t        hold_q;
   seq_slot_t        in0, in1;
   seq_slot_t        out0, out1;

   assign in0 = '{inst: bus.in_inst0_i, ctrl: bus.in_ctrl0_i, pc: bus.in_pc0_i,
                  pred: bus.in_pred0_i, tgt: bus.in_tgt0_i};
   assign in1 = '{inst: bus.in_inst1_i, ctrl: bus.in_ctrl1_i, pc: bus.in_pc1_i,
                  pred: bus.in_pred1_i, tgt: bus.in_tgt1_i};

   issue_hold_reg #(
      .W       (SLOT_W),
      .RST_VAL (NOP_SLOT)
   ) u_hold (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .clr_i   (hold_clr),
      .en_i    (hold_en),
      .d_i     (in1),
      .q_o     (hold_q)
   );

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= SEQ_PASS;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: flush beats stall; stall freezes everything else.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hold_en  = 1'b0;
      hold_clr = 1'b0;
      if (bus.flush_i) begin
         state_d  = SEQ_PASS;
         hold_clr = 1'b1;
      end else if (!bus.stall_i) begin
         unique case (state_q)
            SEQ_PASS: begin
               if (bus.in_valid_i && bus.issue1_special_stall_i) begin
                  state_d = SEQ_REPLAY;
                  hold_en = 1'b1;
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
            SEQ_REPLAY: state_d = SEQ_PASS;
            default:    state_d = SEQ_PASS;
         endcase
      end
   end

   // Outputs. In REPLAY the special stall input is ignored: a lone
   // instruction never needs splitting.
   always_comb begin
      out0           = NOP_SLOT;
      out1           = NOP_SLOT;
      bus.in_ready_o = 1'b0;
      bus.kill1_o    = 1'b0;
      if (state_q == SEQ_REPLAY) begin
         out0 = hold_q;
      end else begin
         bus.in_ready_o = !bus.stall_i && !bus.flush_i;
         bus.kill1_o    = bus.in_valid_i && bus.issue1_special_stall_i;
         if (bus.in_valid_i) begin
            out0 = in0;
            out1 = in1;
         end
      end
   end

   assign bus.out_inst0_o  = out0.inst;
   assign bus.out_ctrl0_o  = out0.ctrl;
   assign bus.out_pc0_o    = out0.pc;
   assign bus.out_pred0_o  = out0.pred;
   assign bus.out_tgt0_o   = out0.tgt;
   assign bus.out_inst1_o  = out1.inst;
   assign bus.out_ctrl1_o  = out1.ctrl;
   assign bus.out_pc1_o    = out1.pc;
   assign bus.out_pred1_o  = out1.pred;
   assign bus.out_tgt1_o   = out1.tgt;
   assign bus.replay_cnt_o = cnt_q;

endmodule

// File: tb/tb_issue_sequencer.sv
// ----------------------------------------------------------------------------
// tb_issue_sequencer
// Self-checking bench for issue_sequencer (counter width 2 so wrap is cheap).
// A queue of parked slot-1 instructions plus a replay tally stand in for the
// design; every cycle the presented pair is checked against them.
// ----------------------------------------------------------------------------
module tb_issue_sequencer;
   import issue_sequencer_pkg::*;

   localparam int          TB_CNT_W = 2;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   issue_sequencer_if #(.CNT_W(TB_CNT_W)) bus ();

   issue_sequencer #(.CNT_W(TB_CNT_W)) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus.slave)
   );

   int tests  = 0;
   int errors = 0;

   // reference state: instructions waiting to be replayed, and replay tally
   seq_slot_t pend[$];
   int        replays = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input seq_slot_t s0, input seq_slot_t s1,
                        input logic sp, input logic st, input logic fl);
      bus.in_valid_i = v;
      bus.in_inst0_i = s0.inst; bus.in_ctrl0_i = s0.ctrl; bus.in_pc0_i = s0.pc;
      bus.in_pred0_i = s0.pred; bus.in_tgt0_i  = s0.tgt;
      bus.in_inst1_i = s1.inst; bus.in_ctrl1_i = s1.ctrl; bus.in_pc1_i = s1.pc;
      bus.in_pred1_i = s1.pred; bus.in_tgt1_i  = s1.tgt;
      bus.issue1_special_stall_i = sp;
      bus.stall_i = st;
      bus.flush_i = fl;
   endtask

   function automatic seq_slot_t mk(input logic [31:0] inst, input logic [31:0] pc);
      seq_slot_t s;
      s.inst = inst; s.ctrl = CTRL_W'(inst ^ 32'h5a5a); s.pc = pc;
      s.pred = inst[3]; s.tgt = pc + 32'h40;
      return s;
   endfunction

   function automatic seq_slot_t rnd_slot();
      seq_slot_t s;
      s.inst = $urandom; s.ctrl = CTRL_W'($urandom); s.pc = $urandom;
      s.pred = 1'($urandom); s.tgt = $urandom;
      return s;
   endfunction

   // Compare the presented outputs with what the reference says must be there.
   task automatic compare();
      seq_slot_t e0;
      seq_slot_t e1;
      logic      held;
      held = (pend.size() != 0);
      chk("replay_cnt", 32'(bus.replay_cnt_o), 32'(replays % (1 << TB_CNT_W)));
      if (held) begin
         e0 = pend[0];
         chk("rp_inst0", bus.out_inst0_o, e0.inst);
         chk("rp_ctrl0", 32'(bus.out_ctrl0_o), 32'(e0.ctrl));
         chk("rp_pc0",   bus.out_pc0_o, e0.pc);
         chk("rp_pred0", 32'(bus.out_pred0_o), 32'(e0.pred));
         chk("rp_tgt0",  bus.out_tgt0_o, e0.tgt);
         chk("rp_slot1", {bus.out_inst1_o ^ NOP, 16'(bus.out_ctrl1_o)} == '0 &&
                         bus.out_pc1_o == 0 && bus.out_tgt1_o == 0 && !bus.out_pred1_o, 32'd1);
         chk("rp_ready", 32'(bus.in_ready_o), 32'd0);
         chk("rp_kill1", 32'(bus.kill1_o), 32'd0);
      end else begin
         chk("ready", 32'(bus.in_ready_o), 32'(!bus.stall_i && !bus.flush_i));
         chk("kill1", 32'(bus.kill1_o), 32'(bus.in_valid_i && bus.issue1_special_stall_i));
         if (bus.in_valid_i) begin
            chk("inst0", bus.out_inst0_o, bus.in_inst0_i);
            chk("ctrl0", 32'(bus.out_ctrl0_o), 32'(bus.in_ctrl0_i));
            chk("pc0",   bus.out_pc0_o, bus.in_pc0_i);
            chk("pred0", 32'(bus.out_pred0_o), 32'(bus.in_pred0_i));
            chk("tgt0",  bus.out_tgt0_o, bus.in_tgt0_i);
            chk("inst1", bus.out_inst1_o, bus.in_inst1_i);
            chk("ctrl1", 32'(bus.out_ctrl1_o), 32'(bus.in_ctrl1_i));
            chk("pc1",   bus.out_pc1_o, bus.in_pc1_i);
            chk("pred1", 32'(bus.out_pred1_o), 32'(bus.in_pred1_i));
            chk("tgt1",  bus.out_tgt1_o, bus.in_tgt1_i);
         end else begin
            chk("nop_inst0", bus.out_inst0_o, NOP);
            chk("nop_ctrl0", 32'(bus.out_ctrl0_o), 32'd0);
            chk("nop_inst1", bus.out_inst1_o, NOP);
            chk("nop_ctrl1", 32'(bus.out_ctrl1_o), 32'd0);
         end
      end
   endtask

   // Clock edge as seen by the reference: what issues, what gets parked.
   task automatic advance();
      if (bus.flush_i) begin
         pend.delete();
      end else if (!bus.stall_i) begin
         if (pend.size() != 0) begin
            void'(pend.pop_front());
         end else if (bus.in_valid_i && bus.issue1_special_stall_i) begin
            pend.push_back('{inst: bus.in_inst1_i, ctrl: bus.in_ctrl1_i, pc: bus.in_pc1_i,
                             pred: bus.in_pred1_i, tgt: bus.in_tgt1_i});
            replays++;
         end
      end
   endtask

   // One cycle: inputs already driven; check at negedge, update at posedge.
   task automatic step();
      @(negedge clk);
      compare();
      @(posedge clk);
      advance();
      #1;
   endtask

   seq_slot_t a0, a1, d0, d1, z;

   initial begin
      z  = '{inst: NOP, ctrl: '0, pc: '0, pred: 1'b0, tgt: '0};
      a0 = mk(32'h003100b3, 32'h0000_1000);   // add x1,x2,x3
      a1 = mk(32'h00628233, 32'h0000_1004);   // add x4,x5,x6
      d0 = mk(32'h00100293, 32'h0000_2000);   // addi x5,x0,1
      d1 = mk(32'h00528333, 32'h0000_2004);   // add x6,x5,x5
      drive(1'b0, z, z, 1'b0, 1'b0, 1'b0);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cnt", 32'(bus.replay_cnt_o), 32'd0);
      chk("rst_inst0", bus.out_inst0_o, NOP);
      chk("rst_ready", 32'(bus.in_ready_o), 32'd1);
      rst = 1'b0;
      step();

      // independent pair
      drive(1'b1, a0, a1, 1'b0, 1'b0, 1'b0);
      step();
      chk("indep_cnt", 32'(bus.replay_cnt_o), 32'd0);

      // dependent pair: split, replay d1 next cycle
      drive(1'b1, d0, d1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("dep_kill1_N", 32'(bus.kill1_o), 32'd1);
      chk("dep_ready_N", 32'(bus.in_ready_o), 32'd1);
      compare();
      @(posedge clk); advance(); #1;
      drive(1'b1, a0, a1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("dep_inst0_N1", bus.out_inst0_o, 32'h00528333);
      chk("dep_pc0_N1", bus.out_pc0_o, 32'h0000_2004);
      chk("dep_inst1_N1", bus.out_inst1_o, 32'h00000013);
      chk("dep_ready_N1", 32'(bus.in_ready_o), 32'd0);
      compare();
      @(posedge clk); advance(); #1;
      drive(1'b1, a0, a1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("dep_cnt_N2", 32'(bus.replay_cnt_o), 32'd1);
      chk("dep_pass_N2", bus.out_inst0_o, 32'h003100b3);
      compare();
      @(posedge clk); advance(); #1;

      // stall held 3 cycles in REPLAY
      drive(1'b1, d0, d1, 1'b1, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, a0, a1, 1'b0, 1'b1, 1'b0);
         @(negedge clk);
         chk("stall_hold_inst0", bus.out_inst0_o, 32'h00528333);
         chk("stall_ready", 32'(bus.in_ready_o), 32'd0);
         compare();
         @(posedge clk); advance(); #1;
      end
      drive(1'b1, a0, a1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("stall_release_inst0", bus.out_inst0_o, 32'h00528333);
      compare();
      @(posedge clk); advance(); #1;
      @(negedge clk);
      chk("stall_pass_inst0", bus.out_inst0_o, 32'h003100b3);
      chk("stall_cnt", 32'(bus.replay_cnt_o), 32'd2);
      compare();
      @(posedge clk); advance(); #1;

      // flush in REPLAY (also with stall asserted)
      drive(1'b1, d0, d1, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b0, z, z, 1'b0, 1'b1, 1'b1);
      step();
      drive(1'b0, z, z, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("flush_inst0", bus.out_inst0_o, NOP);
      chk("flush_cnt", 32'(bus.replay_cnt_o), 32'd3);
      chk("flush_ready", 32'(bus.in_ready_o), 32'd1);
      compare();
      @(posedge clk); advance(); #1;

      // asynchronous reset mid-cycle in REPLAY
      drive(1'b1, d0, d1, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b1, a0, a1, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_cnt", 32'(bus.replay_cnt_o), 32'd0);
      chk("arst_inst0", bus.out_inst0_o, 32'h003100b3);
      chk("arst_ready", 32'(bus.in_ready_o), 32'd1);
      pend.delete();
      replays = 0;
      #1 rst = 1'b0;
      step();

      // counter wrap: five consecutive split pairs -> 1,2,3,0,1
      for (int i = 0; i < 5; i++) begin
         logic [31:0] want;
         drive(1'b1, d0, d1, 1'b1, 1'b0, 1'b0);
         step();
         drive(1'b0, z, z, 1'b0, 1'b0, 1'b0);
         step();
         want = (i == 3) ? 32'd0 : 32'(((i + 1) % 4));
         chk("wrap_cnt", 32'(bus.replay_cnt_o), want);
      end

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), rnd_slot(), rnd_slot(),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0),
               1'($urandom_range(0, 19) == 0));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
